mmio_spi_core: RTL and testbench

SPI master slot core for the MMIO subsystem. It is driven by the MMIO slot bus (cs/read/write/addr/wr_data/rd_data) and exposes one byte-wide full-duplex SPI port with a programmable clock divider, CPOL/CPHA mode and S slave-select lines. Firmware on the MicroBlaze writes a byte, polls ready, then reads back the received byte.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_master_engine.sv | 115 +++++++++++
 rtl/mmio_spi_core.sv | 79 +++++++
 tb/tb_mmio_spi_core.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and register offsets for the MMIO SPI master slot.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CPHA_DELAY,
        P0,
        P1
    } spi_state_t;

    localparam logic [4:0] SPI_RD_DATA = 5'd0;
    localparam logic [4:0] SPI_DVSR    = 5'd1;
    localparam logic [4:0] SPI_SS      = 5'd2;
    localparam logic [4:0] SPI_MODE    = 5'd3;
    localparam logic [4:0] SPI_WR_DATA = 5'd4;

endpackage

// File: rtl/spi_master_engine.sv
// Byte-wide full-duplex SPI master: phase/bit counters, shift registers and sclk generation.
module spi_master_engine
    import spi_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] dvsr,
    input  logic        cpol,
    input  logic        cpha,
    input  logic [7:0]  din,
    input  logic        start,
    input  logic        miso,
    output logic [7:0]  dout,
    output logic        ready,
    output logic        done_tick,
    output logic        sclk,
    output logic        mosi,
    output spi_state_t  state
);

    // Handshake: a start pulse is accepted only on a cycle where ready=1;
    // ready falls the cycle after acceptance and returns once dout holds the new byte.
    spi_state_t  state_reg, state_next;
    logic [15:0] c_reg, c_next;
    logic [2:0]  n_reg, n_next;
    logic [7:0]  so_reg, so_next;
    logic [7:0]  si_reg, si_next;
    logic [7:0]  rx_reg, rx_next;
    logic        phase_end;
    logic        p_clk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            c_reg     <= '0;
            n_reg     <= '0;
            so_reg    <= '0;
            si_reg    <= '0;
            rx_reg    <= '0;
        end else begin
            state_reg <= state_next;
            c_reg     <= c_next;
            n_reg     <= n_next;
            so_reg    <= so_next;
            si_reg    <= si_next;
            rx_reg    <= rx_next;
        end
    end

    assign phase_end = (c_reg == dvsr);

    always_comb begin
        state_next = state_reg;
        c_next     = c_reg;
        n_next     = n_reg;
        so_next    = so_reg;
        si_next    = si_reg;
        rx_next    = rx_reg;
        ready      = 1'b0;
        done_tick  = 1'b0;
        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    so_next    = din;
                    c_next     = '0;
                    n_next     = '0;
                    state_next = cpha ? CPHA_DELAY : P0;
                end
            end
            CPHA_DELAY: begin
                if (phase_end) begin
                    c_next     = '0;
                    state_next = P0;
                end else begin
                    c_next = c_reg + 16'd1;
                end
            end
            P0: begin
                if (phase_end) begin
                    si_next    = {si_reg[6:0], miso};
                    c_next     = '0;
                    state_next = P1;
                end else begin
                    c_next = c_reg + 16'd1;
                end
            end
            P1: begin
                if (phase_end) begin
                    if (n_reg == 3'd7) begin
                        rx_next    = si_reg;
                        done_tick  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        so_next    = {so_reg[6:0], 1'b0};
                        n_next     = n_reg + 3'd1;
                        c_next     = '0;
                        state_next = P0;
                    end
                end else begin
                    c_next = c_reg + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The sclk-active half moves to P0 when cpha=1 so the first edge only launches data.
    assign p_clk = ((state_reg == P1) && !cpha) || ((state_reg == P0) && cpha);
    assign sclk  = cpol ^ p_clk;
    assign mosi  = so_reg[7];
    assign dout  = rx_reg;
    assign state = state_reg;

endmodule

// File: rtl/mmio_spi_core.sv
// MMIO slot wrapper: divisor, slave-select and mode registers plus the status/data read mux.
module mmio_spi_core
    import spi_pkg::*;
#(
    parameter int          S        = 2,
    parameter logic [15:0] DVSR_RST = 16'd49
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    output logic         spi_sclk,
    output logic         spi_mosi,
    input  logic         spi_miso,
    output logic [S-1:0] spi_ss_n
);

    logic [15:0] dvsr_reg;
    logic [S-1:0] ss_reg;
    logic        cpol_reg;
    logic        cpha_reg;
    logic        wr_en;
    logic        start;
    logic        ready;
    logic        done_tick;
    logic [7:0]  rx_byte;
    spi_state_t  engine_state;
    logic        unused_bits;

    assign wr_en = cs && write;
    assign start = wr_en && (addr == SPI_WR_DATA);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dvsr_reg <= DVSR_RST;
            ss_reg   <= '1;
            cpol_reg <= 1'b0;
            cpha_reg <= 1'b0;
        end else if (wr_en) begin
            case (addr)
                SPI_DVSR: dvsr_reg <= wr_data[15:0];
                SPI_SS:   ss_reg   <= wr_data[S-1:0];
                SPI_MODE: begin
                    cpol_reg <= wr_data[0];
                    cpha_reg <= wr_data[1];
                end
                default: ;
            endcase
        end
    end

    spi_master_engine u_engine (
        .clk       (clk),
        .reset_n   (reset_n),
        .dvsr      (dvsr_reg),
        .cpol      (cpol_reg),
        .cpha      (cpha_reg),
        .din       (wr_data[7:0]),
        .start     (start),
        .miso      (spi_miso),
        .dout      (rx_byte),
        .ready     (ready),
        .done_tick (done_tick),
        .sclk      (spi_sclk),
        .mosi      (spi_mosi),
        .state     (engine_state)
    );

    // Status is a pure address mux; the read strobe carries no side effects here.
    assign rd_data  = (addr == SPI_RD_DATA) ? {23'b0, ready, rx_byte} : 32'd0;
    assign spi_ss_n = ss_reg;

    assign unused_bits = &{1'b0, read, wr_data[31:16], done_tick, engine_state};

endmodule

// File: tb/tb_mmio_spi_core.sv
// Directed bench for mmio_spi_core with a transfer-level reference model checked every cycle.
module tb_mmio_spi_core;
    import spi_pkg::*;

    localparam int S = 2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         cs = 1'b0;
    logic         read = 1'b0;
    logic         write = 1'b0;
    logic [4:0]   addr = 5'd0;
    logic [31:0]  wr_data = 32'd0;
    logic [31:0]  rd_data;
    logic         spi_sclk;
    logic         spi_mosi;
    logic         spi_miso;
    logic [S-1:0] spi_ss_n;

    int total = 0;
    int bad = 0;

    // slave side and sclk monitors
    logic       loop_mode = 1'b1;
    logic [7:0] slave_pat = 8'h00;
    logic [2:0] slave_idx;
    logic [7:0] mosi_cap;
    int         rise_cnt;
    logic       clr_mon = 1'b0;
    logic       chk_en = 1'b0;

    mmio_spi_core #(.S(S), .DVSR_RST(16'd49)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cs       (cs),
        .read     (read),
        .write    (write),
        .addr     (addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_ss_n (spi_ss_n)
    );

    always #5 clk = ~clk;

    assign spi_miso = loop_mode ? spi_mosi : slave_pat[~slave_idx];

    always @(posedge spi_sclk or posedge clr_mon) begin
        if (clr_mon) begin
            slave_idx <= 3'd0;
            mosi_cap  <= 8'd0;
            rise_cnt  <= 0;
        end else begin
            if (slave_idx != 3'd7) slave_idx <= slave_idx + 3'd1;
            mosi_cap <= {mosi_cap[6:0], spi_mosi};
            rise_cnt <= rise_cnt + 1;
        end
    end

    // reference model: a transfer is a busy window of len cycles after the start edge
    logic         m_busy;
    int           m_k;
    int           m_len;
    logic [15:0]  m_dvsr;
    logic         m_cpol;
    logic         m_cpha;
    logic [S-1:0] m_ss;
    logic [7:0]   m_tx;
    logic [7:0]   m_rx;
    logic [7:0]   m_rx_next;
    logic         m_last_mosi;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy      <= 1'b0;
            m_k         <= 0;
            m_len       <= 0;
            m_dvsr      <= 16'd49;
            m_cpol      <= 1'b0;
            m_cpha      <= 1'b0;
            m_ss        <= '1;
            m_tx        <= 8'd0;
            m_rx        <= 8'd0;
            m_rx_next   <= 8'd0;
            m_last_mosi <= 1'b0;
        end else begin
            if (m_busy) begin
                if (m_k == m_len - 1) begin
                    m_busy      <= 1'b0;
                    m_rx        <= m_rx_next;
                    m_last_mosi <= m_tx[0];
                end else begin
                    m_k <= m_k + 1;
                end
            end
            if (cs && write) begin
                case (addr)
                    5'd1: m_dvsr <= wr_data[15:0];
                    5'd2: m_ss   <= wr_data[S-1:0];
                    5'd3: begin
                        m_cpol <= wr_data[0];
                        m_cpha <= wr_data[1];
                    end
                    5'd4: if (!m_busy) begin
                        m_busy    <= 1'b1;
                        m_k       <= 0;
                        m_tx      <= wr_data[7:0];
                        m_len     <= (m_cpha ? 17 : 16) * (int'(m_dvsr) + 1);
                        m_rx_next <= loop_mode ? wr_data[7:0] : slave_pat;
                    end
                    default: ;
                endcase
            end
        end
    end

    function automatic logic exp_sclk();
        int ph;
        logic p;
        if (!m_busy) return m_cpol;
        ph = m_k / (int'(m_dvsr) + 1);
        if (m_cpha) p = (ph >= 1) && (((ph - 1) % 2) == 0);
        else        p = (ph % 2) == 1;
        return m_cpol ^ p;
    endfunction

    function automatic logic exp_mosi();
        int ph;
        int b;
        logic [7:0] t;
        if (!m_busy) return m_last_mosi;
        ph = m_k / (int'(m_dvsr) + 1);
        if (m_cpha) b = (ph == 0) ? 0 : (ph - 1) / 2;
        else        b = ph / 2;
        t = m_tx;
        return t[7 - b];
    endfunction

    function automatic logic [31:0] exp_rd();
        if (addr == 5'd0) return {23'b0, !m_busy, m_rx};
        return 32'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            check("cyc_rd", rd_data, exp_rd());
            check("cyc_sclk", {31'b0, spi_sclk}, {31'b0, exp_sclk()});
            check("cyc_mosi", {31'b0, spi_mosi}, {31'b0, exp_mosi()});
            check("cyc_ss", {30'b0, spi_ss_n}, {30'b0, m_ss});
        end
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic c);
        @(negedge clk);
        cs = c;
        write = 1'b1;
        addr = a;
        wr_data = d;
        @(negedge clk);
        cs = 1'b0;
        write = 1'b0;
        addr = 5'd0;
        wr_data = 32'd0;
    endtask

    task automatic clr_monitors();
        @(negedge clk);
        clr_mon = 1'b1;
        #1;
        clr_mon = 1'b0;
    endtask

    // counts status-busy cycles, starting from the cycle right after the start edge
    task automatic wait_ready(output int cnt, input int bound);
        cnt = 1;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            #1;
            if (rd_data[8]) break;
            cnt++;
        end
    endtask

    initial begin
        int cnt;
        read = 1'b0;
        clr_mon = 1'b1;
        #1;
        clr_mon = 1'b0;
        chk_en = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_rd", rd_data, 32'h100);
        check("rst_ss", {30'b0, spi_ss_n}, 32'h3);
        check("rst_sclk", {31'b0, spi_sclk}, 32'h0);
        check("rst_mosi", {31'b0, spi_mosi}, 32'h0);
        reset_n = 1'b1;

        // mode 0 loopback, dvsr=0
        loop_mode = 1'b1;
        wr(5'd1, 32'd0, 1'b1);
        wr(5'd3, 32'd0, 1'b1);
        clr_monitors();
        wr(5'd4, 32'hA5, 1'b1);
        wait_ready(cnt, 100);
        check("m0_len", cnt, 32'd16);
        check("m0_rd", rd_data, 32'h1A5);
        check("m0_rises", rise_cnt, 32'd8);
        check("m0_mosi", {24'b0, mosi_cap}, 32'hA5);

        // mode 3, dvsr=3, slave drives 0x3C
        loop_mode = 1'b0;
        slave_pat = 8'h3C;
        wr(5'd1, 32'd3, 1'b1);
        wr(5'd3, 32'd3, 1'b1);
        check("m3_idle_sclk", {31'b0, spi_sclk}, 32'h1);
        clr_monitors();
        wr(5'd4, 32'h81, 1'b1);
        wait_ready(cnt, 200);
        check("m3_len", cnt, 32'd68);
        check("m3_rd", rd_data, 32'h13C);
        check("m3_mosi", {24'b0, mosi_cap}, 32'h81);
        check("m3_rises", rise_cnt, 32'd8);
        check("m3_end_sclk", {31'b0, spi_sclk}, 32'h1);

        // write while busy is ignored
        loop_mode = 1'b1;
        wr(5'd3, 32'd0, 1'b1);
        wr(5'd1, 32'd0, 1'b1);
        clr_monitors();
        wr(5'd4, 32'h11, 1'b1);
        wr(5'd4, 32'h22, 1'b1);
        wait_ready(cnt, 100);
        check("busy_len", cnt, 32'd14);
        check("busy_rd", rd_data, 32'h111);
        check("busy_mosi", {24'b0, mosi_cap}, 32'h11);

        // slave select, then reset during bit 4
        wr(5'd2, 32'h2, 1'b1);
        check("ss_set", {30'b0, spi_ss_n}, 32'h2);
        wr(5'd1, 32'd1, 1'b1);
        clr_monitors();
        wr(5'd4, 32'h5A, 1'b1);
        repeat (16) @(negedge clk);
        check("mid_rises", rise_cnt, 32'd4);
        check("mid_busy", rd_data, 32'h011);
        reset_n = 1'b0;
        #1;
        check("abort_sclk", {31'b0, spi_sclk}, 32'h0);
        check("abort_ss", {30'b0, spi_ss_n}, 32'h3);
        check("abort_rd", rd_data, 32'h100);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #2;
        check("post_rst_rd", rd_data, 32'h100);

        // cs=0 writes change nothing; default divisor gives 16*50 busy cycles
        wr(5'd1, 32'hFFFF, 1'b0);
        wr(5'd2, 32'h0, 1'b0);
        check("nocs_ss", {30'b0, spi_ss_n}, 32'h3);
        clr_monitors();
        wr(5'd4, 32'hC3, 1'b1);
        wait_ready(cnt, 1000);
        check("dflt_len", cnt, 32'd800);
        check("dflt_rd", rd_data, 32'h1C3);

        // maximum divisor: first sclk rise after 65536 clocks
        wr(5'd1, 32'hFFFF, 1'b1);
        clr_monitors();
        wr(5'd4, 32'hF0, 1'b1);
        cnt = 0;
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
            #1;
            cnt++;
            if (spi_sclk) break;
        end
        check("max_half", cnt, 32'd65536);
        check("max_busy_rd", rd_data, 32'h0C3);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("final_rd", rd_data, 32'h100);
        repeat (2) @(negedge clk);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
